// File: rtl/data_route.sv
// data_route: one-to-two stream router with an independent FIFO per output.
// Each accepted input beat is steered to output A (select=1) or B (select=0).
// Optional feature macro: DATA_ROUTE_CNT_EN adds per-output accepted-beat counters.
module data_route #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic              select,
  output logic [DATA_W-1:0] data_a,
  output logic              valid_a,
  input  logic              ready_a,
  output logic [DATA_W-1:0] data_b,
  output logic              valid_b,
  input  logic              ready_b
`ifdef DATA_ROUTE_CNT_EN
  ,
  input  logic              cnt_clr,
  output logic [15:0]       cnt_a,
  output logic [15:0]       cnt_b
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam int unsigned NQ    = 2;  // index 0 = output A, index 1 = output B

  logic [DATA_W-1:0] mem_q    [NQ][DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [NQ];
  logic [PTR_W-1:0]  rd_ptr_q [NQ];
  logic [OCC_W-1:0]  occ_q    [NQ];

  logic [NQ-1:0] full;
  logic [NQ-1:0] push;
  logic [NQ-1:0] pop;

  // Handshake decode: ready_in looks only at select and registered occupancy
  always_comb begin
    full     = '0;
    push     = '0;
    pop      = '0;
    ready_in = 1'b0;
    full[0]  = (occ_q[0] == OCC_W'(DEPTH));
    full[1]  = (occ_q[1] == OCC_W'(DEPTH));
    ready_in = select ? !full[0] : !full[1];
    push[0]  = valid_in && ready_in && select;
    push[1]  = valid_in && ready_in && !select;
    pop[0]   = (occ_q[0] != '0) && ready_a;
    pop[1]   = (occ_q[1] != '0) && ready_b;
  end

  // FIFO storage, pointers and occupancy for both outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int q = 0; q < int'(NQ); q++) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          mem_q[q][i] <= '0;
        end
        wr_ptr_q[q] <= '0;
        rd_ptr_q[q] <= '0;
        occ_q[q]    <= '0;
      end
    end else begin
      for (int q = 0; q < int'(NQ); q++) begin
        if (push[q]) begin
          mem_q[q][wr_ptr_q[q]] <= data_in;
          wr_ptr_q[q]           <= PTR_W'(wr_ptr_q[q] + 1'b1);
        end
        if (pop[q]) begin
          rd_ptr_q[q] <= PTR_W'(rd_ptr_q[q] + 1'b1);
        end
        case ({push[q], pop[q]})
          2'b10:   occ_q[q] <= OCC_W'(occ_q[q] + 1'b1);
          2'b01:   occ_q[q] <= OCC_W'(occ_q[q] - 1'b1);
          default: occ_q[q] <= occ_q[q];
        endcase
      end
    end
  end

  assign data_a  = mem_q[0][rd_ptr_q[0]];
  assign valid_a = (occ_q[0] != '0);
  assign data_b  = mem_q[1][rd_ptr_q[1]];
  assign valid_b = (occ_q[1] != '0);

`ifdef DATA_ROUTE_CNT_EN
  localparam int unsigned CNT_W = 16;

  // Saturating accepted-beat counters; clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (push[0] && (cnt_a != '1)) cnt_a <= CNT_W'(cnt_a + 1'b1);
      if (push[1] && (cnt_b != '1)) cnt_b <= CNT_W'(cnt_b + 1'b1);
    end
  end
`endif

endmodule
